// File: rtl/mem_arbiter_if.sv
// Bundle of core-side request/response signals and the single-port memory
// command bus shared between the arbiter and its surroundings.
interface mem_arbiter_if #(
  parameter int N = 64
);
  // instruction-fetch port
  logic         ireq;
  logic [N-1:0] iadr;
  logic         ivalid;
  logic [31:0]  irdata;
  // data port
  logic         dreq;
  logic [N-1:0] dadr;
  logic [N-1:0] dwdata;
  logic [1:0]   dwe;
  logic         ddword;
  logic         dvalid;
  logic [N-1:0] drdata;
  // memory command / response
  logic [N-1:0] madr;
  logic [N-1:0] mwdata;
  logic [1:0]   mwe;
  logic         mdword;
  logic [N-1:0] mrdata;
  // core stall
  logic         stall;

  // arbiter side
  modport slave (
    input  ireq, iadr, dreq, dadr, dwdata, dwe, ddword, mrdata,
    output ivalid, irdata, dvalid, drdata, madr, mwdata, mwe, mdword, stall
  );

  // core + memory side
  modport master (
    output ireq, iadr, dreq, dadr, dwdata, dwe, ddword, mrdata,
    input  ivalid, irdata, dvalid, drdata, madr, mwdata, mwe, mdword, stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port
// memory with fixed read latency LAT. The memory command is driven
// combinationally during the grant cycle only (an IDLE cycle with a winning
// request); read data is returned LAT cycles later and presented in the same
// cycle as the valid pulse, then held in a register until the next pulse.
// Stores complete one cycle after the grant. Ties alternate using a
// last-grant flag that starts at "instruction", so data wins the first tie.
// N must be at least 64 (the fetch path selects 32-bit halves of mrdata).
module mem_arbiter #(
  parameter int N   = 64,
  parameter int LAT = 2
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IREAD, DREAD, DWRITE} state_t;

  state_t       state, state_next;
  logic [2:0]   cnt, cnt_next;
  logic         last_data, last_data_next;   // 1: data port got the last grant
  logic         isel, isel_next;             // fetch address bit 2 at grant
  logic         dsel, dsel_next;             // data address bit 2 at grant
  logic         dword, dword_next;           // doubleword load in flight
  logic [31:0]  irdata_hold;
  logic [N-1:0] drdata_hold;

  logic         grant_i, grant_d;
  logic         ivalid_c, dvalid_c, load_done;
  logic [N-1:0] madr_c, mwdata_c;
  logic [1:0]   mwe_c;
  logic         mdword_c;
  logic [31:0]  fetch_word, load_half;
  logic [N-1:0] load_word;

  // Pick a winner in IDLE; on a tie serve the port that was not served last.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE && !reset) begin
      if (bus.ireq && bus.dreq) begin
        if (last_data) grant_i = 1'b1;
        else           grant_d = 1'b1;
      end else if (bus.ireq) begin
        grant_i = 1'b1;
      end else if (bus.dreq) begin
        grant_d = 1'b1;
      end
    end
  end

  // Next-state, latency counter and memory command / valid generation.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    last_data_next = last_data;
    isel_next      = isel;
    dsel_next      = dsel;
    dword_next     = dword;
    madr_c         = '0;
    mwdata_c       = '0;
    mwe_c          = 2'b00;
    mdword_c       = 1'b0;
    ivalid_c       = 1'b0;
    dvalid_c       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_i) begin
          madr_c         = bus.iadr;
          isel_next      = bus.iadr[2];
          last_data_next = 1'b0;
          cnt_next       = 3'd1;
          state_next     = IREAD;
        end else if (grant_d) begin
          madr_c         = bus.dadr;
          mdword_c       = bus.ddword;
          dsel_next      = bus.dadr[2];
          dword_next     = bus.ddword;
          last_data_next = 1'b1;
          if (bus.dwe != 2'b00) begin
            mwdata_c   = bus.dwdata;
            mwe_c      = bus.dwe;
            state_next = DWRITE;
          end else begin
            cnt_next   = 3'd1;
            state_next = DREAD;
          end
        end
      end
      IREAD: begin
        if (cnt == 3'(LAT)) begin
          ivalid_c   = 1'b1;
          cnt_next   = 3'd0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 3'd1;
        end
      end
      DREAD: begin
        if (cnt == 3'(LAT)) begin
          dvalid_c   = 1'b1;
          cnt_next   = 3'd0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 3'd1;
        end
      end
      DWRITE: begin
        dvalid_c   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Word selection and sign extension of the returning memory data.
  always_comb begin
    fetch_word = isel ? bus.mrdata[63:32] : bus.mrdata[31:0];
    load_half  = dsel ? bus.mrdata[63:32] : bus.mrdata[31:0];
    load_word  = dword ? bus.mrdata : {{(N-32){load_half[31]}}, load_half};
  end

  assign load_done = dvalid_c && (state == DREAD);

  // State, grant bookkeeping and held read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      last_data   <= 1'b0;
      isel        <= 1'b0;
      dsel        <= 1'b0;
      dword       <= 1'b0;
      irdata_hold <= '0;
      drdata_hold <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      last_data <= last_data_next;
      isel      <= isel_next;
      dsel      <= dsel_next;
      dword     <= dword_next;
      if (ivalid_c)  irdata_hold <= fetch_word;
      if (load_done) drdata_hold <= load_word;
    end
  end

  assign bus.ivalid = ivalid_c;
  assign bus.dvalid = dvalid_c;
  assign bus.irdata = ivalid_c ? fetch_word : irdata_hold;
  assign bus.drdata = load_done ? load_word : drdata_hold;
  assign bus.madr   = madr_c;
  assign bus.mwdata = mwdata_c;
  assign bus.mwe    = mwe_c;
  assign bus.mdword = mdword_c;
  assign bus.stall  = (bus.ireq & ~ivalid_c) | (bus.dreq & ~dvalid_c);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: reset values, a table of single transactions,
// hand-written tie / reset-abort / continuous-contention sequences, and a
// randomized run against a transaction-timing reference model.
module tb_mem_arbiter;
  localparam int N   = 64;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.N(N)) bus();
  mem_arbiter #(.N(N), .LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Memory model: either a fixed word, or a hashed word of the address that
  // was on madr LAT cycles earlier.
  logic        use_fixed;
  logic [63:0] fixed_rdata;
  logic [63:0] madr_s;
  logic [63:0] pipe [0:7];

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'hF0E1_D2C3_B4A5_9687;
  endfunction

  function automatic logic [31:0] fetch_of(input logic [63:0] w, input logic [63:0] a);
    return a[2] ? w[63:32] : w[31:0];
  endfunction

  function automatic logic [63:0] load_of(input logic [63:0] w, input logic [63:0] a,
                                          input logic dw);
    logic [31:0] h;
    h = a[2] ? w[63:32] : w[31:0];
    return dw ? w : {{32{h[31]}}, h};
  endfunction

  always @(negedge clk) madr_s <= bus.madr;
  always @(posedge clk) begin
    pipe[0] <= madr_s;
    for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.mrdata = use_fixed ? fixed_rdata : mem_word(pipe[LAT-1]);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ireq = 1'b0; bus.iadr = '0;
    bus.dreq = 1'b0; bus.dadr = '0; bus.dwdata = '0; bus.dwe = 2'b00; bus.ddword = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    bit          is_d;
    logic [1:0]  we;
    bit          dw;
    logic [63:0] adr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [63:0] exp_mwdata;
    bit          exp_mdword;
    int          lat;
    logic [63:0] exp_rd;
  } vec_t;

  initial begin
    vec_t        vt [9];
    vec_t        v;
    logic [63:0] last_drd;
    logic [63:0] last_ird;
    int          grants;
    bit          prev_g, g;
    // random-phase state
    bit          i_pend, d_pend;
    int          i_seq, d_seq;
    logic [63:0] i_adr, d_adr, d_wd;
    logic [1:0]  d_we;
    bit          d_dw;
    int          free_at, done_at, g_seq;
    bit          busy, last_d, g_d, g_store, pick_d;
    logic [63:0] g_val;
    logic [31:0] m_ird;
    logic [63:0] m_drd;
    bit          e_iv, e_dv, e_stall, e_gd;
    logic [63:0] e_madr, e_mwd, e_drd;
    logic [1:0]  e_mwe;
    bit          e_mdw;
    logic [31:0] e_ird;

    vt[0] = '{"fetch40",   1'b0, 2'b00, 1'b0, 64'h40,  64'h0, 64'h0000_0000_2008_0005,
              64'h0, 1'b0, LAT, 64'h0000_0000_2008_0005};
    vt[1] = '{"fetch44",   1'b0, 2'b00, 1'b0, 64'h44,  64'h0, 64'hDEAD_BEEF_2008_0005,
              64'h0, 1'b0, LAT, 64'h0000_0000_DEAD_BEEF};
    vt[2] = '{"store54",   1'b1, 2'b01, 1'b0, 64'h54,  64'h7, 64'h0,
              64'h7, 1'b0, 1,   64'h0};
    vt[3] = '{"store_dw",  1'b1, 2'b11, 1'b1, 64'h100, 64'h1122_3344_5566_7788, 64'h0,
              64'h1122_3344_5566_7788, 1'b1, 1, 64'h0};
    vt[4] = '{"store10",   1'b1, 2'b10, 1'b0, 64'h60,  64'hFFFF, 64'h0,
              64'hFFFF, 1'b0, 1, 64'h0};
    vt[5] = '{"ldw_hi_neg", 1'b1, 2'b00, 1'b0, 64'h4,  64'h0, 64'h8000_0000_0000_0000,
              64'h0, 1'b0, LAT, 64'hFFFF_FFFF_8000_0000};
    vt[6] = '{"ldw_lo_pos", 1'b1, 2'b00, 1'b0, 64'h8,  64'h0, 64'h8000_0000_7FFF_FFFF,
              64'h0, 1'b0, LAT, 64'h0000_0000_7FFF_FFFF};
    vt[7] = '{"ldw_lo_neg", 1'b1, 2'b00, 1'b0, 64'h10, 64'h0, 64'h0000_0000_8000_0001,
              64'h0, 1'b0, LAT, 64'hFFFF_FFFF_8000_0001};
    vt[8] = '{"ld_dword",  1'b1, 2'b00, 1'b1, 64'h18,  64'h0, 64'hCAFE_BABE_1234_5678,
              64'h0, 1'b1, LAT, 64'hCAFE_BABE_1234_5678};

    // ---------------- reset state (with a fetch request already raised)
    reset = 1'b1; use_fixed = 1'b1; fixed_rdata = '0;
    idle_inputs();
    bus.ireq = 1'b1; bus.iadr = 64'h40;
    repeat (2) @(negedge clk);
    chk("rst_ivalid", bus.ivalid, 0);
    chk("rst_dvalid", bus.dvalid, 0);
    chk("rst_irdata", bus.irdata, 0);
    chk("rst_drdata", bus.drdata, 0);
    chk("rst_madr",   bus.madr, 0);
    chk("rst_mwdata", bus.mwdata, 0);
    chk("rst_mwe",    bus.mwe, 0);
    chk("rst_mdword", bus.mdword, 0);
    chk("rst_stall",  bus.stall, 1);
    $display("reset: checked");

    // ---------------- tie right after reset: data first, then instruction
    next_cycle();
    reset = 1'b0;
    fixed_rdata = 64'h1111_2222_3333_4444;
    bus.ireq = 1'b1; bus.iadr = 64'h200;
    bus.dreq = 1'b1; bus.dadr = 64'h80; bus.dwe = 2'b00; bus.ddword = 1'b1;
    sample();
    chk("tie_grant_data_madr", bus.madr, 64'h80);
    chk("tie_grant_mdword", bus.mdword, 1);
    chk("tie_grant_mwe", bus.mwe, 0);
    next_cycle(); sample();
    chk("tie_dvalid_early", bus.dvalid, 0);
    chk("tie_mwe_after_grant", bus.mwe, 0);
    next_cycle(); sample();
    chk("tie_dvalid", bus.dvalid, 1);
    chk("tie_no_ivalid", bus.ivalid, 0);
    chk("tie_drdata", bus.drdata, 64'h1111_2222_3333_4444);
    chk("tie_stall_ifetch", bus.stall, 1);
    next_cycle(); bus.dreq = 1'b0; sample();
    chk("tie_grant_instr_madr", bus.madr, 64'h200);
    chk("tie_dvalid_gone", bus.dvalid, 0);
    chk("tie_drdata_hold", bus.drdata, 64'h1111_2222_3333_4444);
    repeat (LAT) next_cycle();
    sample();
    chk("tie_ivalid", bus.ivalid, 1);
    chk("tie_irdata", bus.irdata, 64'h3333_4444);
    next_cycle(); bus.ireq = 1'b0; sample();
    chk("tie_stall_after", bus.stall, 0);
    $display("tie: data then instruction");

    // ---------------- continuous contention: grants alternate, data first
    next_cycle();
    bus.ireq = 1'b1; bus.iadr = 64'h300;
    bus.dreq = 1'b1; bus.dadr = 64'h400; bus.dwe = 2'b00; bus.ddword = 1'b0;
    grants = 0; prev_g = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) next_cycle();
      sample();
      chk("cont_stall", bus.stall, 1);
      chk("cont_both_valid", bus.ivalid & bus.dvalid, 0);
      if (bus.madr == 64'h300 || bus.madr == 64'h400) begin
        g = (bus.madr == 64'h400);
        if (grants == 0) chk("cont_first_is_data", g, 1);
        else             chk("cont_alternate", g, !prev_g);
        prev_g = g;
        grants++;
      end
    end
    chk("cont_grant_count", grants, (20 + LAT) / (LAT + 1));
    $display("contention: %0d grants", grants);
    next_cycle(); idle_inputs();
    repeat (LAT + 1) next_cycle();
    last_drd = 64'h0000_0000_3333_4444;
    last_ird = 64'h0000_0000_3333_4444;

    // ---------------- table of single transactions from IDLE
    for (int i = 0; i < 9; i++) begin
      v = vt[i];
      next_cycle();
      fixed_rdata = v.rdata;
      if (v.is_d) begin
        bus.dreq = 1'b1; bus.dadr = v.adr; bus.dwe = v.we; bus.dwdata = v.wdata;
        bus.ddword = v.dw;
      end else begin
        bus.ireq = 1'b1; bus.iadr = v.adr;
      end
      sample();
      chk({v.name, "_madr"},   bus.madr, v.adr);
      chk({v.name, "_mwe"},    bus.mwe, v.we);
      chk({v.name, "_mwdata"}, bus.mwdata, v.exp_mwdata);
      chk({v.name, "_mdword"}, bus.mdword, v.exp_mdword);
      chk({v.name, "_stall"},  bus.stall, 1);
      for (int k = 1; k <= v.lat; k++) begin
        next_cycle(); sample();
        chk({v.name, "_mwe_idle"}, bus.mwe, 0);
        if (k < v.lat) begin
          chk({v.name, "_valid_early"}, v.is_d ? bus.dvalid : bus.ivalid, 0);
        end else begin
          chk({v.name, "_valid"}, v.is_d ? bus.dvalid : bus.ivalid, 1);
          chk({v.name, "_other_valid"}, v.is_d ? bus.ivalid : bus.dvalid, 0);
          chk({v.name, "_stall_done"}, bus.stall, 0);
          if (!v.is_d)           chk({v.name, "_irdata"}, bus.irdata, v.exp_rd);
          else if (v.we == 2'b00) chk({v.name, "_drdata"}, bus.drdata, v.exp_rd);
          else                    chk({v.name, "_drdata_kept"}, bus.drdata, last_drd);
        end
      end
      next_cycle(); idle_inputs(); sample();
      chk({v.name, "_valid_one_cycle"}, v.is_d ? bus.dvalid : bus.ivalid, 0);
      if (!v.is_d) last_ird = v.exp_rd;
      else if (v.we == 2'b00) last_drd = v.exp_rd;
      chk({v.name, "_irdata_hold"}, bus.irdata, last_ird);
      chk({v.name, "_drdata_hold"}, bus.drdata, last_drd);
      $display("vector %s: adr=%h lat=%0d", v.name, v.adr, v.lat);
    end

    // ---------------- reset one cycle after a load grant
    next_cycle();
    fixed_rdata = 64'h5555_6666_7777_8888;
    bus.dreq = 1'b1; bus.dadr = 64'h8; bus.dwe = 2'b00; bus.ddword = 1'b1;
    sample();
    chk("abort_grant_madr", bus.madr, 64'h8);
    next_cycle();
    reset = 1'b1; idle_inputs();
    sample();
    chk("abort_ivalid", bus.ivalid, 0);
    chk("abort_dvalid", bus.dvalid, 0);
    chk("abort_irdata", bus.irdata, 0);
    chk("abort_drdata", bus.drdata, 0);
    chk("abort_madr",   bus.madr, 0);
    chk("abort_mwdata", bus.mwdata, 0);
    chk("abort_mwe",    bus.mwe, 0);
    chk("abort_mdword", bus.mdword, 0);
    next_cycle(); reset = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      sample();
      chk("abort_no_dvalid", bus.dvalid, 0);
      next_cycle();
    end
    fixed_rdata = 64'h0000_0000_2008_0005;
    bus.ireq = 1'b1; bus.iadr = 64'h40;
    sample();
    chk("abort_next_madr", bus.madr, 64'h40);
    repeat (LAT) next_cycle();
    sample();
    chk("abort_next_ivalid", bus.ivalid, 1);
    chk("abort_next_irdata", bus.irdata, 64'h2008_0005);
    next_cycle(); idle_inputs();
    $display("reset abort: recovered");

    // ---------------- randomized run against the timing model
    reset = 1'b1; sample();
    next_cycle(); reset = 1'b0; use_fixed = 1'b0;
    i_pend = 0; d_pend = 0; i_seq = 0; d_seq = 0;
    i_adr = '0; d_adr = '0; d_wd = '0; d_we = 2'b00; d_dw = 1'b0;
    free_at = 0; done_at = 0; busy = 0; last_d = 0; g_d = 0; g_store = 0; g_seq = 0;
    g_val = '0; m_ird = '0; m_drd = '0;
    for (int t = 0; t < 400; t++) begin
      next_cycle();
      if (i_pend && $urandom_range(0, 19) == 0) i_pend = 0;
      else if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; i_seq++; i_adr = {$urandom, $urandom};
      end
      if (d_pend && $urandom_range(0, 19) == 0) d_pend = 0;
      else if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_seq++; d_adr = {$urandom, $urandom}; d_wd = {$urandom, $urandom};
        d_we = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        d_dw = 1'($urandom_range(0, 1));
      end
      bus.ireq = i_pend; bus.iadr = i_adr;
      bus.dreq = d_pend; bus.dadr = d_adr; bus.dwdata = d_wd; bus.dwe = d_we;
      bus.ddword = d_dw;

      // model: completion of the access in flight, then a possible new grant
      e_iv = 0; e_dv = 0; e_madr = '0; e_mwe = 2'b00; e_mwd = '0; e_mdw = 0; e_gd = 0;
      if (busy && t == done_at) begin
        busy = 0;
        if (g_d) e_dv = 1; else e_iv = 1;
      end
      e_ird = e_iv ? g_val[31:0] : m_ird;
      e_drd = (e_dv && !g_store) ? g_val : m_drd;
      if (!busy && t >= free_at && (i_pend || d_pend)) begin
        pick_d = d_pend && (!i_pend || !last_d);
        last_d = pick_d; busy = 1; g_d = pick_d; e_gd = pick_d;
        if (pick_d) begin
          e_madr = d_adr; e_mdw = d_dw; g_store = (d_we != 2'b00); g_seq = d_seq;
          if (g_store) begin
            e_mwe = d_we; e_mwd = d_wd; done_at = t + 1;
          end else begin
            done_at = t + LAT; g_val = load_of(mem_word(d_adr), d_adr, d_dw);
          end
        end else begin
          e_madr = i_adr; g_store = 0; g_seq = i_seq; done_at = t + LAT;
          g_val = {32'h0, fetch_of(mem_word(i_adr), i_adr)};
        end
        free_at = done_at + 1;
      end
      e_stall = (i_pend && !e_iv) || (d_pend && !e_dv);

      sample();
      chk("rnd_ivalid", bus.ivalid, e_iv);
      chk("rnd_dvalid", bus.dvalid, e_dv);
      chk("rnd_irdata", bus.irdata, e_ird);
      chk("rnd_drdata", bus.drdata, e_drd);
      chk("rnd_madr",   bus.madr, e_madr);
      chk("rnd_mwe",    bus.mwe, e_mwe);
      chk("rnd_stall",  bus.stall, e_stall);
      if (e_gd)          chk("rnd_mdword", bus.mdword, e_mdw);
      if (e_mwe != 2'b00) chk("rnd_mwdata", bus.mwdata, e_mwd);

      m_ird = e_ird;
      m_drd = e_drd;
      if (e_iv) begin
        if (i_pend && g_seq == i_seq) i_pend = 0;
        $display("random t=%0d fetch done irdata=%h", t, e_ird);
      end
      if (e_dv) begin
        if (d_pend && g_seq == d_seq) d_pend = 0;
        $display("random t=%0d %s done drdata=%h", t, g_store ? "store" : "load", e_drd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
